servo_jog_ctrl: RTL and testbench

Multi-channel servo position controller, the bounded and parametrised successor to the single-axis left/right jog logic. Each channel holds a position register that moves in fixed steps. In manual mode a switch pair jogs the channel, with auto-repeat while a switch is held. In automatic mode the channel seeks a commanded target through a valid/ready handshake. Positions saturate at configured limits and never wrap. The block sits between the board switch/command inputs and the per-channel PWM generators, which consume `o_pos`.

---
 rtl/servo_jog_ctrl.sv | 115 +++++++++++
 tb/tb_servo_jog_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_jog_ctrl.sv
// servo_jog_ctrl: multi-channel servo position controller with manual jog (auto-repeat) and handshaked auto seek
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   manual              : 1 = jog switches drive channels, 0 = automatic target seek
//   i_left, i_right     : per-channel jog switches (asynchronous, synchronised here)
//   target_valid/ready  : valid/ready handshake for target_pos
//   target_pos, o_pos   : packed per-channel positions, channel k at [k*POS_W +: POS_W]
//   o_at_limit          : per-channel position equals POS_MIN or POS_MAX
//   o_busy, o_done      : any channel active / one-cycle pulse when an auto seek completes
module servo_jog_ctrl #(
  parameter int CHANNELS   = 2,
  parameter int POS_W      = 12,
  parameter int STEP       = 8,
  parameter int POS_MIN    = 100,
  parameter int POS_MAX    = 4000,
  parameter int POS_INIT   = 2048,
  parameter int REPEAT_CYC = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      manual,
  input  logic [CHANNELS-1:0]       i_left,
  input  logic [CHANNELS-1:0]       i_right,
  input  logic                      target_valid,
  output logic                      target_ready,
  input  logic [CHANNELS*POS_W-1:0] target_pos,
  output logic [CHANNELS*POS_W-1:0] o_pos,
  output logic [CHANNELS-1:0]       o_at_limit,
  output logic                      o_busy,
  output logic                      o_done
);
  localparam int CW = $clog2(REPEAT_CYC + 1);
  localparam logic [CW-1:0] RLD = CW'(REPEAT_CYC - 1);
  localparam logic [POS_W-1:0] PMIN = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] PMAX = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] PINIT = POS_W'(POS_INIT);
  localparam logic [POS_W:0] STW = (POS_W + 1)'(STEP);
  localparam logic [POS_W:0] MINW = (POS_W + 1)'(POS_MIN);
  localparam logic [POS_W:0] MAXW = (POS_W + 1)'(POS_MAX);
  typedef enum logic [1:0] {IDLE, LEFT, RIGHT, SEEK} state_t;
  logic [1:0] man_q;
  logic [CHANNELS-1:0] l_q, l_s, r_q, r_s, busy, seek, nidle;
  logic man_s, acc;
  assign man_s = man_q[1];
  assign acc = target_valid && target_ready && !man_s;
  assign o_busy = |busy;
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t st, ns;
    logic [CW-1:0] cnt, cnt_n;
    logic [POS_W-1:0] pos, pos_n, tgt, tc, tin;
    logic [POS_W:0] pw, ew, dw, mv;
    logic step;
    assign tin = target_pos[g*POS_W +: POS_W];
    assign tc = tin < PMIN ? PMIN : (tin > PMAX ? PMAX : tin);
    // Arithmetic is one bit wider so pos-STEP / pos+STEP cannot wrap before saturation.
    always_comb begin
      pw = {1'b0, pos};
      ew = {1'b0, acc ? tc : tgt};
      dw = ew > pw ? ew - pw : pw - ew;
      mv = dw > STW ? STW : dw;
      ns = IDLE;
      step = 1'b0;
      pos_n = pos;
      if (man_s) begin
        ns = (l_s[g] && !r_s[g]) ? LEFT : ((r_s[g] && !l_s[g]) ? RIGHT : IDLE);
        step = ns != IDLE && (ns != st || cnt == '0);
        if (step)
          pos_n = ns == LEFT ? POS_W'(pw >= MINW + STW ? pw - STW : MINW)
                             : POS_W'(pw + STW > MAXW ? MAXW : pw + STW);
      end else if (acc || st == SEEK) begin
        // acceptance applies the first seek step on the same edge
        step = acc ? dw != '0 : cnt == '0;
        if (step)
          pos_n = POS_W'(ew > pw ? pw + mv : pw - mv);
        ns = pos_n == ew[POS_W-1:0] ? IDLE : SEEK;
      end
      cnt_n = ns == IDLE ? '0 : (step ? RLD : cnt - CW'(1));
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        st  <= IDLE;
        cnt <= '0;
        pos <= PINIT;
        tgt <= PINIT;
      end else begin
        st  <= ns;
        cnt <= cnt_n;
        pos <= pos_n;
        tgt <= acc ? tc : tgt;
      end
    assign o_pos[g*POS_W +: POS_W] = pos;
    assign o_at_limit[g] = pos == PMIN || pos == PMAX;
    assign busy[g] = st != IDLE;
    assign seek[g] = st == SEEK;
    assign nidle[g] = ns == IDLE;
  end
  // done fires when an accepted seek leaves every channel idle without a manual abort
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      man_q        <= '0;
      l_q          <= '0;
      l_s          <= '0;
      r_q          <= '0;
      r_s          <= '0;
      target_ready <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      man_q        <= {man_q[0], manual};
      l_q          <= i_left;
      l_s          <= l_q;
      r_q          <= i_right;
      r_s          <= r_q;
      target_ready <= !man_s && &nidle && !acc;
      o_done       <= !man_s && (acc || |seek) && &nidle;
    end
endmodule

// File: tb/tb_servo_jog_ctrl.sv
// tb_servo_jog_ctrl: directed + random stimulus against an event-time reference model of servo_jog_ctrl
module tb_servo_jog_ctrl;
  localparam int CH = 2, W = 12, STEP = 8, PMIN = 100, PMAX = 4000, PINIT = 2048, R = 4;
  logic clk = 1'b0, rst_n = 1'b0, manual = 1'b0, target_valid = 1'b0;
  logic [CH-1:0] i_left = '0, i_right = '0;
  logic [CH*W-1:0] target_pos = '0;
  logic target_ready, o_busy, o_done;
  logic [CH*W-1:0] o_pos;
  logic [CH-1:0] o_at_limit;
  int errors = 0, checks = 0, np;
  logic [W-1:0] snap0, snap1;

  servo_jog_ctrl #(.CHANNELS(CH), .POS_W(W), .STEP(STEP), .POS_MIN(PMIN), .POS_MAX(PMAX),
                   .POS_INIT(PINIT), .REPEAT_CYC(R)) dut (
    .clk(clk), .rst_n(rst_n), .manual(manual), .i_left(i_left), .i_right(i_right),
    .target_valid(target_valid), .target_ready(target_ready), .target_pos(target_pos),
    .o_pos(o_pos), .o_at_limit(o_at_limit), .o_busy(o_busy), .o_done(o_done));

  always #5 clk = ~clk;

  // Reference model: per-channel mode (-1 left, +1 right, 2 seek, 0 idle) and the absolute
  // edge number at which the next repeat step is due; inputs delayed via a sample history.
  int m_pos[CH], m_tgt[CH], m_mode[CH], m_due[CH];
  int e;
  logic m_ready, m_done, m_seeking;
  logic mq[$];
  logic [CH-1:0] lq[$], rq[$];

  function automatic int clampi(int v);
    return v < PMIN ? PMIN : (v > PMAX ? PMAX : v);
  endfunction

  function automatic int approach(int p, int t);
    int mag;
    mag = t > p ? t - p : p - t;
    if (mag > STEP) mag = STEP;
    return t > p ? p + mag : p - mag;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < CH; k++) begin
      m_pos[k] = PINIT; m_tgt[k] = PINIT; m_mode[k] = 0; m_due[k] = 0;
    end
    mq.delete(); lq.delete(); rq.delete();
    e = 0; m_ready = 1'b0; m_done = 1'b0; m_seeking = 1'b0;
  endtask

  task automatic m_edge();
    logic ms, acc;
    logic [CH-1:0] ls, rs;
    int d;
    bit all_idle;
    mq.push_back(manual); lq.push_back(i_left); rq.push_back(i_right);
    ms = mq.size() >= 3 ? mq[mq.size()-3] : 1'b0;
    ls = lq.size() >= 3 ? lq[lq.size()-3] : '0;
    rs = rq.size() >= 3 ? rq[rq.size()-3] : '0;
    acc = target_valid && m_ready && !ms;
    for (int k = 0; k < CH; k++) begin
      if (ms) begin
        d = (ls[k] && !rs[k]) ? -1 : ((rs[k] && !ls[k]) ? 1 : 0);
        if (d == 0) m_mode[k] = 0;
        else if (m_mode[k] != d || e == m_due[k]) begin
          m_pos[k] = clampi(m_pos[k] + d * STEP); m_due[k] = e + R; m_mode[k] = d;
        end
      end else if (acc) begin
        m_tgt[k] = clampi(int'(target_pos[k*W +: W]));
        m_mode[k] = 0;
        if (m_tgt[k] != m_pos[k]) begin
          m_pos[k] = approach(m_pos[k], m_tgt[k]); m_due[k] = e + R;
          m_mode[k] = m_pos[k] == m_tgt[k] ? 0 : 2;
        end
      end else if (m_mode[k] == 2) begin
        if (e == m_due[k]) begin
          m_pos[k] = approach(m_pos[k], m_tgt[k]); m_due[k] = e + R;
          if (m_pos[k] == m_tgt[k]) m_mode[k] = 0;
        end
      end else m_mode[k] = 0;
    end
    all_idle = 1;
    for (int k = 0; k < CH; k++) if (m_mode[k] != 0) all_idle = 0;
    m_done = 1'b0;
    if (ms) m_seeking = 1'b0;
    else if (acc) m_seeking = 1'b1;
    if (m_seeking && all_idle) begin m_done = 1'b1; m_seeking = 1'b0; end
    m_ready = !ms && all_idle && !acc;
    e++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic busy_e;
    logic [CH-1:0] lim_e;
    @(posedge clk);
    m_edge();
    #1;
    busy_e = 1'b0;
    for (int k = 0; k < CH; k++) begin
      chk($sformatf("pos%0d@%0d", k, e), o_pos[k*W +: W], m_pos[k]);
      lim_e[k] = m_pos[k] == PMIN || m_pos[k] == PMAX;
      if (m_mode[k] != 0) busy_e = 1'b1;
    end
    chk($sformatf("limit@%0d", e), o_at_limit, lim_e);
    chk($sformatf("busy@%0d", e), o_busy, busy_e);
    chk($sformatf("done@%0d", e), o_done, m_done);
    chk($sformatf("ready@%0d", e), target_ready, m_ready);
  endtask

  task automatic run_count(input int n);
    np = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (o_done) np++;
    end
  endtask

  task automatic check_reset();
    chk("rst_pos", o_pos, 24'h800800);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_ready", target_ready, 0);
    chk("rst_limit", o_at_limit, 0);
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(39) == 0) manual = ~manual;
      if ($urandom_range(7) == 0) i_left = CH'($urandom);
      if ($urandom_range(7) == 0) i_right = CH'($urandom);
      target_valid = $urandom_range(2) == 0;
      target_pos = {12'($urandom), 12'($urandom)};
      cyc();
    end
    target_valid = 1'b0;
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1 check_reset();
    @(negedge clk) rst_n = 1'b1;
    repeat (3) cyc();
    chk("ready_after_rst", target_ready, 1);
    // manual jog right on ch0
    manual = 1'b1;
    repeat (3) cyc();
    i_right = 2'b01;
    repeat (2) cyc();
    chk("jog_pre", o_pos[11:0], 2048);
    cyc();
    chk("jog_first", o_pos[11:0], 2056);
    chk("jog_ch1", o_pos[23:12], 2048);
    repeat (17) cyc();
    i_right = '0;
    repeat (4) cyc();
    chk("jog_hold", o_pos[11:0], 2088);
    chk("jog_idle", o_busy, 0);
    // both switches on ch0
    i_left = 2'b01; i_right = 2'b01;
    repeat (8) cyc();
    chk("both_pos", o_pos[11:0], 2088);
    chk("both_busy", o_busy, 0);
    i_left = '0; i_right = '0;
    // auto seek with clamped ch1 target
    manual = 1'b0;
    repeat (4) cyc();
    chk("auto_ready", target_ready, 1);
    target_pos = {12'd30, 12'd2070}; target_valid = 1'b1;
    cyc();
    target_valid = 1'b0;
    chk("auto_first", o_pos[11:0], 2080);
    chk("auto_ready_drop", target_ready, 0);
    run_count(1200);
    chk("auto_done_pulses", np, 1);
    chk("auto_ch0", o_pos[11:0], 2070);
    chk("auto_ch1", o_pos[23:12], 100);
    chk("auto_limit", o_at_limit, 2'b10);
    // saturation at POS_MAX then POS_MIN on ch1
    target_pos = {12'd3988, 12'd2070}; target_valid = 1'b1;
    cyc();
    target_valid = 1'b0;
    run_count(2100);
    chk("sat_seek_pulses", np, 1);
    chk("sat_seek_ch1", o_pos[23:12], 3988);
    manual = 1'b1; i_right = 2'b10;
    repeat (3) cyc();
    chk("sat_first", o_pos[23:12], 3996);
    repeat (4) cyc();
    chk("sat_max", o_pos[23:12], 4000);
    repeat (20) cyc();
    chk("sat_max_hold", o_pos[23:12], 4000);
    chk("sat_max_limit", o_at_limit[1], 1);
    chk("sat_max_busy", o_busy, 1);
    i_right = '0; i_left = 2'b10;
    repeat (2000) cyc();
    chk("sat_min", o_pos[23:12], 100);
    chk("sat_min_limit", o_at_limit[1], 1);
    i_left = '0;
    // abort a seek by raising manual
    manual = 1'b0;
    repeat (4) cyc();
    target_pos = {12'd2000, 12'd3000}; target_valid = 1'b1;
    cyc();
    target_valid = 1'b0;
    repeat (20) cyc();
    manual = 1'b1;
    run_count(3);
    snap0 = o_pos[11:0]; snap1 = o_pos[23:12];
    chk("abort_busy", o_busy, 0);
    run_count(10);
    chk("abort_no_done", np, 0);
    chk("abort_hold0", o_pos[11:0], snap0);
    chk("abort_hold1", o_pos[23:12], snap1);
    manual = 1'b0;
    repeat (4) cyc();
    target_pos = {12'd120, 12'd2500}; target_valid = 1'b1;
    cyc();
    target_valid = 1'b0;
    run_count(1000);
    chk("reseek_pulses", np, 1);
    chk("reseek_ch0", o_pos[11:0], 2500);
    chk("reseek_ch1", o_pos[23:12], 120);
    // random traffic, a mid-run reset, more random traffic
    random_run(400);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset();
    m_reset();
    @(negedge clk) rst_n = 1'b1;
    random_run(400);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
